// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchronizer, debounce filter,
// mode-qualified edge events, stretched output pulse and sticky status flag.
module multi_edge_detector #(
    parameter int unsigned      WIDTH           = 1,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 1,
    parameter int unsigned      PULSE_CYCLES    = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     signal_in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     status_clear,
    output logic [WIDTH-1:0]     edge_detect_pulse,
    output logic [WIDTH-1:0]     level_out,
    output logic [WIDTH-1:0]     edge_seen
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PCNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYCLES);

    logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
    logic [CNT_W-1:0]  r_cnt  [WIDTH];
    logic [PCNT_W-1:0] r_pcnt [WIDTH];

    logic [WIDTH-1:0]  w_sync;
    logic [CNT_W-1:0]  w_cnt_nxt  [WIDTH];
    logic [PCNT_W-1:0] w_pcnt_nxt [WIDTH];
    logic [WIDTH-1:0]  w_accept;
    logic [WIDTH-1:0]  w_event;
    logic [WIDTH-1:0]  w_pulse_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchronizer shift chain, all channels in parallel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= RESET_LEVEL;
            end
        end else begin
            r_sync[0] <= signal_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Debounce acceptance, mode qualification and pulse counter next state
    always_comb begin
        w_accept    = '0;
        w_event     = '0;
        w_pulse_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i]  = '0;
            w_pcnt_nxt[i] = r_pcnt[i];
            if (w_sync[i] != level_out[i]) begin
                if (r_cnt[i] == DEB_LAST) begin
                    w_accept[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
            // New level 1 is a rising edge (mode bit 0), 0 is falling (mode bit 1)
            w_event[i] = w_accept[i] & (w_sync[i] ? mode[2*i] : mode[2*i+1]);
            if (w_event[i]) begin
                w_pcnt_nxt[i] = PULSE_LOAD;
            end else if (r_pcnt[i] != '0) begin
                w_pcnt_nxt[i] = r_pcnt[i] - 1'b1;
            end
            w_pulse_nxt[i] = (w_pcnt_nxt[i] != '0);
        end
    end

    // Per-channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_out         <= RESET_LEVEL;
            edge_detect_pulse <= '0;
            edge_seen         <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i]  <= '0;
                r_pcnt[i] <= '0;
            end
        end else begin
            level_out         <= level_out ^ w_accept;
            edge_detect_pulse <= w_pulse_nxt;
            edge_seen         <= w_event | (edge_seen & ~status_clear);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i]  <= w_cnt_nxt[i];
                r_pcnt[i] <= w_pcnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: two instances (debounce 4 and 1) driven by
// shared stimulus and checked every cycle against a behavioural model.
module tb_multi_edge_detector;

    localparam int unsigned W  = 2;
    localparam int unsigned SS = 2;
    localparam int unsigned PC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0]   signal_in = '0;
    logic [2*W-1:0] mode = '0;
    logic [W-1:0]   status_clear = '0;
    logic [W-1:0]   a_pulse, a_level, a_seen;
    logic [W-1:0]   b_pulse, b_level, b_seen;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(PC), .RESET_LEVEL(2'b00)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .mode(mode),
        .status_clear(status_clear), .edge_detect_pulse(a_pulse),
        .level_out(a_level), .edge_seen(a_seen)
    );

    multi_edge_detector #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1), .PULSE_CYCLES(PC), .RESET_LEVEL(2'b00)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .mode(mode),
        .status_clear(status_clear), .edge_detect_pulse(b_pulse),
        .level_out(b_level), .edge_seen(b_seen)
    );

    // Reference model: index k selects instance (0: debounce 4, 1: debounce 1)
    int       deb [2] = '{4, 1};
    logic [W-1:0] m_q[$];
    logic     m_lvl   [2][W];
    int       m_run   [2][W];
    int       m_since [2][W];
    logic     m_seen  [2][W];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = {};
            for (int s = 0; s < SS; s++) m_q.push_back('0);
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < W; c++) begin
                    m_lvl[k][c] = 1'b0;
                    m_run[k][c] = 0;
                    m_since[k][c] = PC;
                    m_seen[k][c] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < W; c++) begin
                    logic s;
                    logic ev;
                    s  = m_q[0][c];
                    ev = 1'b0;
                    if (s != m_lvl[k][c]) begin
                        m_run[k][c]++;
                        if (m_run[k][c] == deb[k]) begin
                            m_lvl[k][c] = s;
                            m_run[k][c] = 0;
                            ev = s ? mode[2*c] : mode[2*c+1];
                        end
                    end else begin
                        m_run[k][c] = 0;
                    end
                    if (ev) m_since[k][c] = 0;
                    else if (m_since[k][c] < PC) m_since[k][c]++;
                    m_seen[k][c] = ev | (m_seen[k][c] & ~status_clear[c]);
                end
            end
            void'(m_q.pop_front());
            m_q.push_back(signal_in);
        end
    end

    function automatic logic [W-1:0] exp_lvl(int k);
        logic [W-1:0] r;
        for (int c = 0; c < W; c++) r[c] = m_lvl[k][c];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_pulse(int k);
        logic [W-1:0] r;
        for (int c = 0; c < W; c++) r[c] = (m_since[k][c] < PC);
        return r;
    endfunction

    function automatic logic [W-1:0] exp_seen(int k);
        logic [W-1:0] r;
        for (int c = 0; c < W; c++) r[c] = m_seen[k][c];
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("a_level", 32'(a_level), 32'(exp_lvl(0)));
        check_eq("a_pulse", 32'(a_pulse), 32'(exp_pulse(0)));
        check_eq("a_seen",  32'(a_seen),  32'(exp_seen(0)));
        check_eq("b_level", 32'(b_level), 32'(exp_lvl(1)));
        check_eq("b_pulse", 32'(b_pulse), 32'(exp_pulse(1)));
        check_eq("b_seen",  32'(b_seen),  32'(exp_seen(1)));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic run_count(input int n, input int k, input int c, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            if (k == 0 ? a_pulse[c] : b_pulse[c]) cnt++;
        end
    endtask

    initial begin
        int cnt;
        int cnt2;
        int hold;

        // Reset state
        step(3);
        check_eq("rst_outs", 32'({a_pulse, a_level, a_seen, b_pulse, b_level, b_seen}), 32'd0);
        rst_n = 1'b1;

        // Latency: rising on ch0 only
        mode = 4'b0101;
        step(3);
        signal_in = 2'b01;
        step(2);
        check_eq("b_lat2", 32'(b_pulse), 32'd0);
        step(1);
        check_eq("b_lat3", 32'(b_pulse), 32'b01);
        check_eq("b_lvl3", 32'(b_level), 32'b01);
        step(2);
        check_eq("a_lat5", 32'(a_pulse), 32'd0);
        step(1);
        check_eq("a_lat6", 32'(a_pulse), 32'b01);
        check_eq("a_lvl6", 32'(a_level), 32'b01);
        check_eq("b_lat6", 32'(b_pulse), 32'd0);
        step(4);

        // Debounce: 3-cycle glitch rejected by A, then 6-cycle high accepted
        signal_in = 2'b00;
        step(12);
        signal_in = 2'b01;
        step(3);
        signal_in = 2'b00;
        step(10);
        check_eq("a_glitch", 32'(a_level[0]), 32'd0);
        signal_in = 2'b01;
        step(5);
        check_eq("a_deb5", 32'(a_pulse[0]), 32'd0);
        step(1);
        check_eq("a_deb6", 32'(a_pulse[0]), 32'd1);
        check_eq("a_deblv", 32'(a_level[0]), 32'd1);
        step(6);
        signal_in = 2'b00;
        step(12);

        // Mode both, then falling only, on ch1
        mode = 4'b1101;
        signal_in = 2'b10;
        run_count(10, 0, 1, cnt);
        signal_in = 2'b00;
        run_count(14, 0, 1, cnt2);
        check_eq("a_both", 32'(cnt + cnt2), 32'd6);
        mode = 4'b1001;
        signal_in = 2'b10;
        run_count(10, 0, 1, cnt);
        check_eq("a_fall_r", 32'(cnt), 32'd0);
        signal_in = 2'b00;
        run_count(14, 0, 1, cnt);
        check_eq("a_fall_f", 32'(cnt), 32'd3);

        // Retrigger on B ch0: three toggles two cycles apart
        mode = 4'b1111;
        step(4);
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || i == 2 || i == 4) signal_in[0] = ~signal_in[0];
            step(1);
            if (b_pulse[0]) cnt++;
        end
        check_eq("b_retrig", 32'(cnt), 32'd7);
        check_eq("b_rt_seen", 32'(b_seen[0]), 32'd1);

        // Status clear: simultaneous with event, then alone
        status_clear = 2'b01;
        step(1);
        status_clear = 2'b00;
        check_eq("b_clr0", 32'(b_seen[0]), 32'd0);
        signal_in[0] = 1'b0;
        step(2);
        status_clear = 2'b01;
        step(1);
        check_eq("b_setwin", 32'(b_seen[0]), 32'd1);
        step(1);
        status_clear = 2'b00;
        check_eq("b_clr1", 32'(b_seen[0]), 32'd0);
        step(12);

        // Reset in cycle 2 of a pulse on B
        mode = 4'b0101;
        signal_in = 2'b01;
        step(4);
        check_eq("b_prerst", 32'(b_pulse[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("b_rst_p", 32'(b_pulse), 32'd0);
        check_eq("b_rst_s", 32'(b_seen), 32'd0);
        check_eq("b_rst_l", 32'(b_level), 32'd0);
        check_all();
        signal_in = 2'b00;
        step(2);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            step(1);
            if ((a_pulse | b_pulse) != '0) cnt++;
        end
        check_eq("post_rst", 32'(cnt), 32'd0);

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                signal_in = W'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 49) == 0) mode = (2*W)'($urandom);
            status_clear = ($urandom_range(0, 9) == 0) ? W'($urandom) : '0;
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised successor to the single-cycle edge detector: WIDTH independent channels.
- Each channel has an input synchronizer, a debounce filter and a selectable edge mode (rising/falling/both/off).
- Each detected edge produces an output pulse of configurable length, plus a sticky per-channel status bit.
- Sits between raw asynchronous inputs (buttons, switches, external strobes) and the FSMs that consume single events.

Parameters:
- WIDTH, 1, number of independent channels.
- SYNC_STAGES, 2, synchronizer flop depth; legal range >=1.
- DEBOUNCE_CYCLES, 1, consecutive cycles a synchronized change must persist before acceptance; legal range >=1. A value of 1 means no filtering.
- PULSE_CYCLES, 1, output pulse length in clk cycles; legal range >=1.
- RESET_LEVEL, {WIDTH{1'b0}}, per-channel value loaded into the synchronizer and debounced-level flops at reset.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- signal_in, input, WIDTH, raw asynchronous inputs.
- mode, input, 2*WIDTH, per-channel mode; bits [2i+1:2i] belong to channel i. Encoding: 00 off, 01 rising, 10 falling, 11 both.
- status_clear, input, WIDTH, synchronous per-channel clear of edge_seen.
- edge_detect_pulse, output, WIDTH, per-channel event pulse, PULSE_CYCLES wide.
- level_out, output, WIDTH, per-channel debounced level.
- edge_seen, output, WIDTH, sticky flag: an edge was detected since the last clear.

Behaviour:
- Reset (rst_n low, asynchronous), values held while rst_n is low:
  - synchronizer flops and level_out = RESET_LEVEL
  - debounce counters = 0, pulse counters = 0
  - edge_detect_pulse = 0, edge_seen = 0
- Reset release: no pulse if signal_in already equals RESET_LEVEL. Otherwise the change is processed as a normal edge.
- Synchronizer: SYNC_STAGES-deep shift per channel; its last stage is sync_i.
- Debounce, per channel:
  - counter cnt_i (width $clog2(DEBOUNCE_CYCLES+1)).
  - When sync_i == level_out_i: cnt_i <= 0.
  - When sync_i != level_out_i and cnt_i == DEBOUNCE_CYCLES-1: level_out_i <= sync_i, cnt_i <= 0, and an edge event is raised in the same cycle.
  - Otherwise, while sync_i != level_out_i: cnt_i increments.
  - A glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles is discarded with no level change.
- Edge event qualification: event_i occurs when level_out_i changes and the mode allows it.
  - Rising = 0->1, allowed when mode bit 0 is set.
  - Falling = 1->0, allowed when mode bit 1 is set.
  - mode 00 still updates level_out but never raises event_i.
  - mode is sampled combinationally in the cycle of the level change.
- Latency: the edge where signal_in is first captured is edge 1. level_out and edge_detect_pulse go high together at edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults this is edge 3.
- Pulse generator, per channel:
  - pcnt_i (width $clog2(PULSE_CYCLES+1)).
  - event_i loads pcnt_i with PULSE_CYCLES. While pcnt_i != 0, it decrements each cycle.
  - edge_detect_pulse_i = (pcnt_i != 0), driven from a register with no combinational path from inputs.
  - Exactly PULSE_CYCLES cycles high per isolated event.
- Retrigger: an event while a pulse is active reloads pcnt_i to PULSE_CYCLES. The pulse is extended, not doubled; no gap is inserted.
- Mode change mid-pulse: the active pulse runs to completion. The new mode affects only later events.
- edge_seen:
  - set on event_i; cleared by status_clear_i.
  - Simultaneous set and clear: set wins.
  - Clear with no event: edge_seen_i goes to 0 the following cycle.
- Channels are fully independent; simultaneous events on several channels each produce their own pulse.
- Reset mid-pulse or mid-debounce: all counters zero immediately and outputs drop asynchronously.

Test Plan:
- Bench parameters: WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_CYCLES=3 unless stated.
- Defaults (WIDTH=2, DEB=1, PULSE=1), mode=2'b01 both channels: signal_in 00->01 held 5 cycles -> edge_detect_pulse[0] high exactly 1 cycle at edge 3 after capture; bit 1 stays 0.
- Debounce: 3-cycle high glitch on ch0 -> no pulse, level_out[0] stays 0. Then a 6-cycle high -> level_out[0]=1 and pulse high 3 cycles starting at edge 6 after capture.
- Mode both (11) on ch1: 0->1 held 10 cycles, then 1->0 held 10 cycles -> two 3-cycle pulses. Mode falling (10): the rising edge gives no pulse, the falling edge gives one pulse.
- Retrigger, DEB=1, PULSE=3, both mode: toggle ch0 every 2 cycles for 3 toggles -> continuous pulse, high 2+2+3=7 cycles; edge_seen[0]=1.
- Status: status_clear[0] asserted in the same cycle as an event -> edge_seen[0] stays 1. Clear one cycle later with no event -> edge_seen[0]=0.
- Reset mid-pulse, PULSE=3: drop rst_n during cycle 2 of a pulse -> edge_detect_pulse, edge_seen and level_out go to 0 immediately. After release with signal_in=RESET_LEVEL, no pulse appears for 10 cycles.
